// File: rtl/him_writer_pkg.sv
// Shared parameters, event record layout and slot helpers for the HCM-to-HIM writer.
// Everything that both the writer FSM and its event FIFO must agree on lives here.
package him_writer_pkg;

  localparam int ROWBITS     = 11;
  localparam int HITINFOBITS = 32;
  localparam int MAXHITS     = 4;
  localparam int MAXHITNBITS = 3;
  localparam int SLOTBITS    = 2;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_AW     = 3;
  localparam int CNTW        = MAXHITNBITS + 1;

  // Packed FIFO word, LSB first: hit info, nNew, nOld, row.
  localparam int EV_INFO_LSB = 0;
  localparam int EV_NNEW_LSB = EV_INFO_LSB + HITINFOBITS * MAXHITS;
  localparam int EV_NOLD_LSB = EV_NNEW_LSB + MAXHITNBITS;
  localparam int EV_ROW_LSB  = EV_NOLD_LSB + MAXHITNBITS;
  localparam int EV_W        = EV_ROW_LSB + ROWBITS;

  typedef struct packed {
    logic [ROWBITS-1:0]             row;
    logic [MAXHITNBITS-1:0]         n_old;
    logic [MAXHITNBITS-1:0]         n_new;
    logic [HITINFOBITS*MAXHITS-1:0] info;
  } hit_event_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  function automatic logic [MAXHITNBITS-1:0] clamp_hits(input logic [CNTW-1:0] n);
    if (n > CNTW'(MAXHITS)) begin
      return MAXHITNBITS'(MAXHITS);
    end else begin
      return n[MAXHITNBITS-1:0];
    end
  endfunction

  function automatic logic [HITINFOBITS-1:0] get_slot(input logic [HITINFOBITS*MAXHITS-1:0] info,
                                                      input logic [SLOTBITS-1:0]              idx);
    return info[int'(idx)*HITINFOBITS +: HITINFOBITS];
  endfunction

endpackage

// File: rtl/him_writer_if.sv
// Bundle of the writer's event input, HIM write port, completion summary and status.
// The master modport is the writer itself; slave is the surrounding HCM/HIM environment.
interface him_writer_if import him_writer_pkg::*; ();

  logic                           in_valid;
  logic                           in_ready;
  logic [ROWBITS-1:0]             in_row;
  logic [MAXHITNBITS-1:0]         in_nOldHits;
  logic [MAXHITNBITS-1:0]         in_nNewHits;
  logic [HITINFOBITS*MAXHITS-1:0] in_hitInfo;
  logic                           him_we;
  logic [ROWBITS-1:0]             him_row;
  logic [SLOTBITS-1:0]            him_slot;
  logic [HITINFOBITS-1:0]         him_data;
  logic                           him_ready;
  logic                           done_valid;
  logic [ROWBITS-1:0]             done_row;
  logic [MAXHITNBITS-1:0]         done_nHits;
  logic                           overflow;
  logic                           truncated;
  logic [7:0]                     drop_count;
  logic                           busy;

  modport master (
    input  in_valid, in_row, in_nOldHits, in_nNewHits, in_hitInfo, him_ready,
    output in_ready, him_we, him_row, him_slot, him_data,
    output done_valid, done_row, done_nHits, overflow, truncated, drop_count, busy
  );

  modport slave (
    output in_valid, in_row, in_nOldHits, in_nNewHits, in_hitInfo, him_ready,
    input  in_ready, him_we, him_row, him_slot, him_data,
    input  done_valid, done_row, done_nHits, overflow, truncated, drop_count, busy
  );

endinterface

// File: rtl/him_event_fifo.sv
// Synchronous first-word-fall-through FIFO holding HCM events awaiting the writer FSM.
// Full/empty are decoded from the registered count so in_ready has no path from pop.
module him_event_fifo import him_writer_pkg::*; #(
  parameter int W     = EV_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/him_writer.sv
// Turns each buffered HCM event into one HIM slot write per new hit at slot nOld+k,
// clipping at row capacity and pulsing a per-event completion summary.
module him_writer import him_writer_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  him_writer_if.master bus
);

  hit_event_t                     push_ev_s;
  hit_event_t                     pop_ev_s;
  logic                           fifo_full_s;
  logic                           fifo_empty_s;
  logic                           push_s;
  logic                           pop_s;

  wr_state_e                      state_q;
  logic [ROWBITS-1:0]             row_q;
  logic [MAXHITNBITS-1:0]         n_old_q;
  logic [MAXHITNBITS-1:0]         n_new_q;
  logic [HITINFOBITS*MAXHITS-1:0] info_q;
  logic [MAXHITNBITS-1:0]         k_q;
  logic                           him_we_q;
  logic [ROWBITS-1:0]             him_row_q;
  logic [SLOTBITS-1:0]            him_slot_q;
  logic [HITINFOBITS-1:0]         him_data_q;
  logic                           done_valid_q;
  logic [ROWBITS-1:0]             done_row_q;
  logic [MAXHITNBITS-1:0]         done_nhits_q;
  logic                           overflow_q;
  logic                           truncated_q;
  logic [7:0]                     drop_count_q;

  logic [CNTW-1:0]                pos_d;
  logic [CNTW-1:0]                next_pos_d;
  logic [MAXHITNBITS-1:0]         k_d;
  logic [CNTW-1:0]                total_d;

  assign push_ev_s = '{row: bus.in_row, n_old: bus.in_nOldHits,
                       n_new: bus.in_nNewHits, info: bus.in_hitInfo};
  assign push_s    = bus.in_valid && !fifo_full_s;
  assign pop_s     = (state_q == ST_IDLE) && !fifo_empty_s;

  him_event_fifo #(.W(EV_W), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push_s),
    .wdata_i (push_ev_s),
    .pop_i   (pop_s),
    .rdata_o (pop_ev_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Slot arithmetic is one bit wider than the counts so nOld+k never wraps below MAXHITS.
  assign pos_d      = {1'b0, n_old_q} + {1'b0, k_q};
  assign next_pos_d = pos_d + CNTW'(1);
  assign k_d        = k_q + MAXHITNBITS'(1);
  assign total_d    = {1'b0, n_old_q} + {1'b0, n_new_q};

  // Event sequencing FSM with registered HIM and completion outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      n_old_q      <= '0;
      n_new_q      <= '0;
      info_q       <= '0;
      k_q          <= '0;
      him_we_q     <= 1'b0;
      him_row_q    <= '0;
      him_slot_q   <= '0;
      him_data_q   <= '0;
      done_valid_q <= 1'b0;
      done_row_q   <= '0;
      done_nhits_q <= '0;
      truncated_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            row_q   <= pop_ev_s.row;
            n_old_q <= pop_ev_s.n_old;
            n_new_q <= clamp_hits({1'b0, pop_ev_s.n_new});
            info_q  <= pop_ev_s.info;
            k_q     <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          done_row_q   <= row_q;
          done_nhits_q <= clamp_hits(total_d);
          if (n_new_q == '0) begin
            done_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (pos_d >= CNTW'(MAXHITS)) begin
            truncated_q  <= 1'b1;
            done_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            him_we_q   <= 1'b1;
            him_row_q  <= row_q;
            him_slot_q <= pos_d[SLOTBITS-1:0];
            him_data_q <= get_slot(info_q, k_q[SLOTBITS-1:0]);
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.him_ready) begin
            k_q <= k_d;
            if (k_d == n_new_q) begin
              him_we_q     <= 1'b0;
              done_valid_q <= 1'b1;
              state_q      <= ST_DONE;
            end else if (next_pos_d >= CNTW'(MAXHITS)) begin
              him_we_q     <= 1'b0;
              truncated_q  <= 1'b1;
              done_valid_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              him_slot_q <= next_pos_d[SLOTBITS-1:0];
              him_data_q <= get_slot(info_q, k_d[SLOTBITS-1:0]);
            end
          end
        end
        ST_DONE: begin
          done_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          him_we_q     <= 1'b0;
          done_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  // Drop accounting for events offered while the FIFO is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (bus.in_valid && fifo_full_s) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 8'd255) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  assign bus.in_ready   = !fifo_full_s;
  assign bus.him_we     = him_we_q;
  assign bus.him_row    = him_row_q;
  assign bus.him_slot   = him_slot_q;
  assign bus.him_data   = him_data_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_row   = done_row_q;
  assign bus.done_nHits = done_nhits_q;
  assign bus.overflow   = overflow_q;
  assign bus.truncated  = truncated_q;
  assign bus.drop_count = drop_count_q;
  assign bus.busy       = !fifo_empty_s || (state_q != ST_IDLE);

endmodule

// File: tb/tb_him_writer.sv
// Scoreboard bench for him_writer: directed events push hand-computed HIM writes and
// completion summaries into queues that a negedge monitor pops and compares.
module tb_him_writer;
  import him_writer_pkg::*;

  localparam int WW = ROWBITS + SLOTBITS + HITINFOBITS;
  localparam int DW = ROWBITS + MAXHITNBITS;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   done_cnt;
  logic [WW-1:0] wq[$];
  logic [DW-1:0] dq[$];
  logic [WW-1:0] w_exp;
  logic [DW-1:0] d_exp;

  him_writer_if bus();

  him_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic exp_write(input logic [ROWBITS-1:0] r, input logic [SLOTBITS-1:0] s,
                           input logic [HITINFOBITS-1:0] d);
    wq.push_back({r, s, d});
  endtask

  task automatic exp_done(input logic [ROWBITS-1:0] r, input logic [MAXHITNBITS-1:0] n);
    dq.push_back({r, n});
  endtask

  // Drives one event for exactly one clock edge; returns #1 after that edge.
  task automatic send(input logic [ROWBITS-1:0] r, input logic [MAXHITNBITS-1:0] nold,
                      input logic [MAXHITNBITS-1:0] nnew, input logic [HITINFOBITS*MAXHITS-1:0] info);
    bus.in_valid    = 1'b1;
    bus.in_row      = r;
    bus.in_nOldHits = nold;
    bus.in_nNewHits = nnew;
    bus.in_hitInfo  = info;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout busy=%0b expected=0", nm, bus.busy);
    end
    chk({nm, "_writes_left"}, 64'(wq.size()), 64'd0);
    chk({nm, "_dones_left"}, 64'(dq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    wq.delete();
    dq.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted HIM write and every done pulse must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.him_we && bus.him_ready) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=%0h expected=none", {bus.him_row, bus.him_slot, bus.him_data});
        end else begin
          w_exp = wq.pop_front();
          chk("him_write", 64'({bus.him_row, bus.him_slot, bus.him_data}), 64'(w_exp));
        end
      end
      if (bus.done_valid) begin
        done_cnt++;
        if (dq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=%0h expected=none", {bus.done_row, bus.done_nHits});
        end else begin
          d_exp = dq.pop_front();
          chk("done_summary", 64'({bus.done_row, bus.done_nHits}), 64'(d_exp));
        end
      end
    end
  end

  initial begin
    int d0;
    int we_seen;
    bit got;
    total = 0;
    bad = 0;
    done_cnt = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_row = '0;
    bus.in_nOldHits = '0;
    bus.in_nNewHits = '0;
    bus.in_hitInfo = '0;
    bus.him_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_him_we", 64'(bus.him_we), 64'd0);
    chk("rst_done_valid", 64'(bus.done_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_flags", 64'({bus.overflow, bus.truncated, bus.drop_count}), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic: latency of writes at cycles 3,4 and done at cycle 5.
    exp_write(11'd5, 2'd0, 32'hA);
    exp_write(11'd5, 2'd1, 32'hB);
    exp_done(11'd5, 3'd2);
    send(11'd5, 3'd0, 3'd2, {32'h0, 32'h0, 32'hB, 32'hA});
    @(negedge clk); chk("basic_we_c1", 64'(bus.him_we), 64'd0);
    @(negedge clk); chk("basic_we_c2", 64'(bus.him_we), 64'd0);
    @(negedge clk); chk("basic_we_c3", 64'(bus.him_we), 64'd1);
    @(negedge clk); chk("basic_slot_c4", 64'({bus.him_we, bus.him_slot}), 64'h5);
    chk("basic_done_c4", 64'(bus.done_valid), 64'd0);
    @(negedge clk); chk("basic_done_c5", 64'(bus.done_valid), 64'd1);
    chk("basic_we_c5", 64'(bus.him_we), 64'd0);
    wait_idle(20, "basic");
    chk("basic_truncated", 64'(bus.truncated), 64'd0);

    // Backpressure: HIM stalls the first write for 3 cycles.
    d0 = done_cnt;
    bus.him_ready = 1'b0;
    exp_write(11'd5, 2'd0, 32'hA);
    exp_write(11'd5, 2'd1, 32'hB);
    exp_done(11'd5, 3'd2);
    send(11'd5, 3'd0, 3'd2, {32'h0, 32'h0, 32'hB, 32'hA});
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", 64'({bus.him_we, bus.him_row, bus.him_slot, bus.him_data}),
          64'({1'b1, 11'd5, 2'd0, 32'hA}));
      if (i == 2) begin
        @(posedge clk);
        #1;
        bus.him_ready = 1'b1;
      end
    end
    wait_idle(20, "bp");
    chk("bp_done_once", 64'(done_cnt - d0), 64'd1);

    // Saturation: one write then clip; then a row that is already full.
    exp_write(11'd7, 2'd3, 32'hC);
    exp_done(11'd7, 3'd4);
    send(11'd7, 3'd3, 3'd2, {32'h0, 32'h0, 32'hD, 32'hC});
    wait_idle(20, "sat1");
    chk("sat1_truncated", 64'(bus.truncated), 64'd1);
    do_reset();
    chk("sat_rst_truncated", 64'(bus.truncated), 64'd0);
    exp_done(11'd9, 3'd4);
    send(11'd9, 3'd4, 3'd1, {32'h0, 32'h0, 32'h0, 32'hF});
    wait_idle(20, "sat2");
    chk("sat2_truncated", 64'(bus.truncated), 64'd1);

    // Zero-hit event followed by a single-hit event on a partly filled row.
    exp_done(11'd3, 3'd2);
    exp_write(11'd4, 2'd2, 32'hE);
    exp_done(11'd4, 3'd3);
    send(11'd3, 3'd2, 3'd0, {32'h0, 32'h0, 32'h0, 32'h1});
    send(11'd4, 3'd2, 3'd1, {32'h0, 32'h0, 32'h0, 32'hE});
    wait_idle(30, "mixed");

    // Overflow: HIM stalled, 10 back-to-back events; the 10th must be dropped.
    d0 = done_cnt;
    bus.him_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("ovf_ready_9th", 64'(bus.in_ready), 64'd1);
      if (i == 9) begin
        chk("ovf_ready_full", 64'(bus.in_ready), 64'd0);
        chk("ovf_flag_before", 64'(bus.overflow), 64'd0);
      end
      if (i < 9) begin
        exp_write(11'(20 + i), 2'd0, 32'(256 + i));
        exp_done(11'(20 + i), 3'd1);
      end
      send(11'(20 + i), 3'd0, 3'd1, {96'h0, 32'(256 + i)});
    end
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    chk("ovf_drop_count", 64'(bus.drop_count), 64'd1);
    bus.him_ready = 1'b1;
    wait_idle(200, "ovf");
    chk("ovf_done_pulses", 64'(done_cnt - d0), 64'd9);

    // Reset during WRITE of a 3-hit event with two more queued.
    bus.him_ready = 1'b0;
    send(11'd30, 3'd0, 3'd3, {32'h0, 32'h3, 32'h2, 32'h1});
    send(11'd31, 3'd0, 3'd1, {96'h0, 32'h4});
    send(11'd32, 3'd0, 3'd1, {96'h0, 32'h5});
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.him_we) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_reached_write", 64'(got), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_async_outputs", 64'({bus.him_we, bus.him_slot, bus.him_data, bus.done_valid, bus.busy}), 64'd0);
    chk("mid_async_in_ready", 64'(bus.in_ready), 64'd1);
    wq.delete();
    dq.delete();
    @(negedge clk);
    reset = 1'b1;
    bus.him_ready = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.him_we) we_seen++;
    end
    chk("mid_no_writes", 64'(we_seen), 64'd0);
    chk("mid_busy", 64'(bus.busy), 64'd0);
    chk("mid_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_flags", 64'({bus.overflow, bus.truncated, bus.drop_count}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/him_writer.md
Name: him_writer

Overview:
- Stage directly downstream of the hit count map (HCM) and upstream of the hit info memory (HIM).
- Consumes each HCM output event: SSID row, number of pre-existing hits, number of new hits, and packed new hit info.
- Buffers events in a small FIFO and issues one HIM slot write per new hit, at slot index nOldHits+k.
- Clips at HIM row capacity and emits a per-event completion summary.

Parameters:
- ROWBITS, 11, width of HCM row index (SSID row).
- HITINFOBITS, 32, width of one hit-info word.
- MAXHITS, 4, hit slots per HIM row.
- MAXHITNBITS, 3, width of hit counts; must satisfy 2^MAXHITNBITS > MAXHITS.
- SLOTBITS, 2, clog2(MAXHITS).
- FIFO_DEPTH, 8, input event FIFO depth (power of two).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  HCM event strobe (connects to HCM newOutput).
- in_ready  out  1  FIFO can accept an event this cycle.
- in_row  in  ROWBITS  SSID row of the event.
- in_nOldHits  in  MAXHITNBITS  hits already stored for this row.
- in_nNewHits  in  MAXHITNBITS  new hits in this event.
- in_hitInfo  in  HITINFOBITS*MAXHITS  packed new hit info; slot k = bits [k*HITINFOBITS +: HITINFOBITS].
- him_we  out  1  HIM write request.
- him_row  out  ROWBITS  HIM row address.
- him_slot  out  SLOTBITS  HIM slot in row.
- him_data  out  HITINFOBITS  hit info to write.
- him_ready  in  1  HIM accepts the write this cycle.
- done_valid  out  1  one-cycle pulse per completed event.
- done_row  out  ROWBITS  row of the completed event.
- done_nHits  out  MAXHITNBITS  min(nOld+nNew, MAXHITS).
- overflow  out  1  sticky: event dropped on full FIFO.
- truncated  out  1  sticky: hit dropped on full row.
- drop_count  out  8  count of dropped events, saturates at 255.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO emptied; FSM to IDLE.
  - All outputs 0, except in_ready=1.
  - Sticky flags and drop_count cleared.
  - Reset mid-burst abandons the event in progress; no further him_we until new input arrives.
- Input handshake:
  - in_ready = (fifo_count < FIFO_DEPTH), taken from the registered count only; no combinational path from pop.
  - in_valid && in_ready pushes {row, nOld, nNew, hitInfo}.
  - in_valid && !in_ready drops the event: overflow<=1, drop_count++ (saturating at 255).
  - A push and a pop in the same cycle leave the count unchanged.
- FSM states: IDLE, LOAD, WRITE, DONE.
  - IDLE: FIFO non-empty -> pop into working registers, k<=0, go to LOAD.
  - LOAD: compute pos = nOld + k in MAXHITNBITS+1 bits.
    - nNew==0 -> DONE.
    - pos >= MAXHITS -> truncated<=1, DONE.
    - Otherwise -> WRITE.
  - WRITE: him_we=1, him_row=row, him_slot=pos[SLOTBITS-1:0], him_data=slot k of hitInfo.
    - Outputs are registered and held stable while him_ready=0.
    - On him_ready: k++.
    - If k+1 == nNew -> DONE.
    - Else if nOld+k+1 >= MAXHITS -> truncated<=1 (remaining hits discarded), DONE.
    - Else stay in WRITE with the next slot.
  - DONE: one-cycle done_valid with done_row and done_nHits; go to IDLE.
- Latency, empty FIFO, him_ready=1:
  - Event accepted at cycle 0, popped at cycle 1, LOAD at cycle 2.
  - First him_we at cycle 3; one write per cycle after that.
  - done_valid one cycle after the last accepted write.
- Throughput: nNew+3 cycles per event; n=0 events take 3 cycles.
- nNew > MAXHITS is treated as MAXHITS; slots above MAXHITS-1 are never read.

Decomposition:
- Shared package/header (alongside the existing parameters include):
  - ROWBITS, HITINFOBITS, MAXHITS, MAXHITNBITS, SLOTBITS.
  - Event record layout (field offsets of the packed FIFO word).
- One sub-module: him_event_fifo.
  - Synchronous FIFO, width ROWBITS+2*MAXHITNBITS+HITINFOBITS*MAXHITS, depth FIFO_DEPTH.
  - Registered count, full/empty, async active-low reset.
- FSM and slot arithmetic stay in him_writer.

Test Plan:
- Basic: event row=5, nOld=0, nNew=2, info {slot0=0xA, slot1=0xB}, him_ready=1 -> him_we at cycles 3,4 with (5,0,0xA), (5,1,0xB); done_valid at cycle 5 with row=5, nHits=2; truncated=0.
- Saturation: row=7, nOld=3, nNew=2, info {0xC,0xD} -> exactly one write (7,3,0xC); truncated=1; done_nHits=4. Also row=9, nOld=4, nNew=1 -> no write, truncated=1, done_nHits=4.
- Backpressure: basic event with him_ready low for 3 cycles at first write -> him_we, him_row, him_slot, him_data stable for 4 cycles; writes complete in order; done_valid once.
- Overflow: him_ready=0, 10 back-to-back events with nNew=1 -> in_ready falls after the 8th FIFO push (9th event is in the FSM); 10th event dropped; overflow=1, drop_count=1. Then him_ready=1 -> 9 done pulses in input order.
- Zero-hit and mixed: events nNew=0 (row 3) then nNew=1 (row 4, nOld=2, info 0xE) -> row 3 has done_valid with nHits=2 and no write; row 4 writes (4,2,0xE); done_nHits=3.
- Reset mid-operation: assert reset during WRITE of a 3-hit event with 2 more events queued -> outputs 0 asynchronously; after release busy=0, no him_we, in_ready=1, flags cleared.
